ps2_kb_rx: RTL

//  PS/2 keyboard receiver with scan-code FIFO. Sits directly upstream of the CPU

---
 rtl/kb_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/ps2_kb_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   KbWidth        : scan-code byte width
//   PS2_FRAME_BITS : start + 8 data + parity + stop
//   kb_state_t     : receiver FSM states
//   odd_parity()   : parity bit that makes {data, parity} contain an odd number of ones
package kb_pkg;

   localparam int KbWidth        = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      KB_IDLE  = 2'd0,
      KB_RECV  = 2'd1,
      KB_CHECK = 2'd2
   } kb_state_t;

   function automatic logic odd_parity(input logic [KbWidth-1:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (empties the FIFO)
//   push  : write din this cycle (dropped if full and no pop in the same cycle)
//   din   : write data
//   pop   : remove the head entry (ignored while empty)
//   dout  : head entry, all zeros while empty
//   empty : no entries
//   full  : DEPTH entries
//   drop  : push rejected this cycle because the FIFO was full
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra MSB on each pointer distinguishes full from empty when the low bits match.
   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   // A pop frees a slot in the same cycle, so push+pop on a full FIFO both proceed.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign drop      = push & full & ~w_do_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
   end

   assign dout = empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver with scan-code FIFO feeding the CPU mmio keyboard port.
// Deserialises 11-bit PS/2 frames (start, D0..D7 LSB first, odd parity, stop),
// rejects malformed or stalled frames and buffers good bytes.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   ps2_clk      : PS/2 clock pin (asynchronous)
//   ps2_data     : PS/2 data pin (asynchronous)
//   sig_rd_kb    : one-cycle pop strobe from the CPU
//   kb_rdata     : FIFO head byte, 0 when empty
//   kb_ready     : FIFO not empty
//   kb_overflow  : sticky, a good byte was dropped on a full FIFO
//   kb_frame_err : one-cycle pulse when a frame is rejected
module ps2_kb_rx
   import kb_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   input  logic               sig_rd_kb,
   output logic [KbWidth-1:0] kb_rdata,
   output logic               kb_ready,
   output logic               kb_overflow,
   output logic               kb_frame_err
);

   localparam int              TO_W     = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
   localparam int              SHIFT_W  = PS2_FRAME_BITS - 1;
   localparam logic [3:0]      BIT_LAST = 4'(PS2_FRAME_BITS - 1);

   // Pin synchronisers; all load 1 so reset release never looks like a falling edge.
   logic r_clk_s1, r_clk_s2, r_clk_s2_d;
   logic r_data_s1, r_data_s2;
   logic w_fall;

   kb_state_t          r_state, w_state_next;
   logic [3:0]         r_bitcnt, w_bitcnt_next;
   logic [SHIFT_W-1:0] r_shift, w_shift_next;
   logic [TO_W-1:0]    r_tocnt, w_tocnt_next;
   logic               w_push_next, w_err_next;
   logic               w_pass;

   logic               r_push;
   logic [KbWidth-1:0] r_push_data;
   logic               r_frame_err;
   logic               r_overflow;

   logic               w_empty, w_full, w_drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_s2_d <= 1'b1;
         r_data_s1  <= 1'b1;
         r_data_s2  <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_s2_d <= r_clk_s2;
         r_data_s1  <= ps2_data;
         r_data_s2  <= r_data_s1;
      end
   end

   assign w_fall = r_clk_s2_d & ~r_clk_s2;

   // After the stop-bit fall the shift register holds {stop, parity, D7..D0}.
   assign w_pass = r_shift[SHIFT_W-1] &
                   (r_shift[KbWidth] == odd_parity(r_shift[KbWidth-1:0]));

   always_comb begin
      w_state_next  = r_state;
      w_bitcnt_next = r_bitcnt;
      w_shift_next  = r_shift;
      w_tocnt_next  = r_tocnt;
      w_push_next   = 1'b0;
      w_err_next    = 1'b0;
      unique case (r_state)
         KB_IDLE: begin
            // A fall with data high is line noise, not a start bit.
            if (w_fall && !r_data_s2) begin
               w_state_next  = KB_RECV;
               w_bitcnt_next = 4'd1;
               w_tocnt_next  = '0;
            end
         end
         KB_RECV: begin
            if (w_fall) begin
               w_shift_next  = {r_data_s2, r_shift[SHIFT_W-1:1]};
               w_bitcnt_next = r_bitcnt + 4'd1;
               w_tocnt_next  = '0;
               if (r_bitcnt == BIT_LAST) w_state_next = KB_CHECK;
            end else if (r_tocnt == TO_MAX) begin
               // Device stopped clocking mid-frame: abandon it.
               w_state_next = KB_IDLE;
               w_err_next   = 1'b1;
            end else begin
               w_tocnt_next = r_tocnt + TO_ONE;
            end
         end
         KB_CHECK: begin
            w_state_next = KB_IDLE;
            if (w_pass) w_push_next = 1'b1;
            else        w_err_next  = 1'b1;
         end
         default: w_state_next = KB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= KB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_tocnt     <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_bitcnt    <= w_bitcnt_next;
         r_shift     <= w_shift_next;
         r_tocnt     <= w_tocnt_next;
         r_push      <= w_push_next;
         r_push_data <= r_shift[KbWidth-1:0];
         r_frame_err <= w_err_next;
      end
   end

   sync_fifo #(
      .WIDTH (KbWidth),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_push),
      .din   (r_push_data),
      .pop   (sig_rd_kb),
      .dout  (kb_rdata),
      .empty (w_empty),
      .full  (w_full),
      .drop  (w_drop)
   );

   // A drop can only happen on a full FIFO; the qualifier keeps the flag honest
   // if the FIFO's drop semantics ever change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop && w_full) begin
         r_overflow <= 1'b1;
      end
   end

   assign kb_ready     = ~w_empty;
   assign kb_overflow  = r_overflow;
   assign kb_frame_err = r_frame_err;

endmodule
